// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard/stall
// controller (hazard_ctrl_unit) and its optional performance counters
// (enabled with HAZARD_PERF_CNT_EN).
package hazard_pkg;

   // Memory-wait FSM: RUN is the normal flowing pipeline, MEM_WAIT holds
   // everything while the data memory has not completed an access.
   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam int REG_ADDR_W      = 5;
   localparam int PERF_CNT_W      = 32;
   localparam int MEM_TIMEOUT_DEF = 64;

   // A source register creates a dependency only if the instruction really
   // reads it and the producer writes something other than x0.
   function automatic logic src_match(
      input logic [REG_ADDR_W-1:0] rd,
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  uses
   );
      return uses && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: three free-running 32-bit event counters (load-use
// stalls, frozen cycles, branch flushes). Instantiated by hazard_ctrl_unit
// only when HAZARD_PERF_CNT_EN is defined. Counters wrap at 2^32.
module hazard_perf_counters
   import hazard_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lu_stall,
   input  logic                  mem_wait,
   input  logic                  flush,
   output logic [PERF_CNT_W-1:0] perf_lu_stalls,
   output logic [PERF_CNT_W-1:0] perf_mem_wait,
   output logic [PERF_CNT_W-1:0] perf_flushes
);

   // Count each qualified event once per cycle; natural overflow wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lu_stalls <= '0;
         perf_mem_wait  <= '0;
         perf_flushes   <= '0;
      end else begin
         if (lu_stall) perf_lu_stalls <= perf_lu_stalls + 1'b1;
         if (mem_wait) perf_mem_wait  <= perf_mem_wait + 1'b1;
         if (flush)    perf_flushes   <= perf_flushes + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush controller for the 5-stage core.
// Detects unresolvable load-use hazards, branch redirects and data-memory
// wait states, and drives the PC / pipeline-register enables, flushes and
// bubbles combinationally. A two-state FSM plus a saturating watchdog
// counter tracks memory waits and raises a sticky mem_err on timeout.
// Optional feature: define HAZARD_PERF_CNT_EN to add perf counter outputs.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic                  if_id_uses_rs1,
   input  logic                  if_id_uses_rs2,
   input  logic                  id_ex_MemRead,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_write,
   output logic                  mem_wb_bubble,
   output logic                  mem_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_lu_stalls,
   output logic [PERF_CNT_W-1:0] perf_mem_wait,
   output logic [PERF_CNT_W-1:0] perf_flushes
`endif
);

   localparam logic [TMO_W-1:0] CNT_MAX = TMO_W'(MEM_TIMEOUT);

   hz_state_t        state, state_nxt;
   logic [TMO_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             mem_err_nxt;
   logic             freeze;
   logic             lu;

   assign lu = id_ex_MemRead &&
               (src_match(id_ex_rd, if_id_rs1, if_id_uses_rs1) ||
                src_match(id_ex_rd, if_id_rs2, if_id_uses_rs2));

   // Next-state and freeze decode for the memory-wait FSM.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_nxt = state;
      freeze    = 1'b0;
      case (state)
         RUN: begin
            if (dmem_req && !dmem_ready) begin
               freeze    = 1'b1;
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) state_nxt = RUN;
            else            freeze    = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Watchdog: clear on entry to MEM_WAIT, count MEM_WAIT cycles up to the
   // timeout and saturate there; mem_err latches once the limit is hit.
   always_comb begin
      wait_cnt_nxt = wait_cnt;
      mem_err_nxt  = mem_err;
      if (state == RUN && state_nxt == MEM_WAIT)
         wait_cnt_nxt = '0;
      else if (state == MEM_WAIT && wait_cnt != CNT_MAX)
         wait_cnt_nxt = wait_cnt + 1'b1;
      if (wait_cnt_nxt == CNT_MAX)
         mem_err_nxt = 1'b1;
   end

   // State, watchdog and error flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         mem_err  <= mem_err_nxt;
      end
   end

   // Pipeline controls by priority: reset, freeze, branch, load-use, run.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      if (rst) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (freeze) begin
         // A branch seen here stays in EX; its flush fires once unfrozen.
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters u_perf (
      .clk            (clk),
      .rst            (rst),
      .lu_stall       (lu && !freeze),
      .mem_wait       (freeze),
      .flush          (ex_branch_taken && !freeze),
      .perf_lu_stalls (perf_lu_stalls),
      .perf_mem_wait  (perf_mem_wait),
      .perf_flushes   (perf_flushes)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed self-checking bench for hazard_ctrl_unit.
// Two instances share stimulus: one with the default timeout and one with
// MEM_TIMEOUT=4 for the watchdog. Perf counters are checked when
// HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_unit;
   import hazard_pkg::*;

   // Control vector order: {pc_write, if_id_write, if_id_flush,
   //                        id_ex_flush, ex_mem_write, mem_wb_bubble}
   localparam logic [5:0] C_RUN    = 6'b110010;
   localparam logic [5:0] C_STALL  = 6'b000110;
   localparam logic [5:0] C_BRANCH = 6'b111110;
   localparam logic [5:0] C_FREEZE = 6'b000001;
   localparam logic [5:0] C_RESET  = 6'b001101;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [REG_ADDR_W-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic                  if_id_uses_rs1, if_id_uses_rs2, id_ex_MemRead;
   logic                  ex_branch_taken, dmem_req, dmem_ready;

   logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble, mem_err;
   logic pc_write4, if_id_write4, if_id_flush4, id_ex_flush4, ex_mem_write4, mem_wb_bubble4, mem_err4;
   logic [5:0] ctl, ctl4;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] p_lu, p_mw, p_fl, p_lu4, p_mw4, p_fl4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit u_dut (
      .clk(clk), .rst(rst),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
      .id_ex_MemRead(id_ex_MemRead), .id_ex_rd(id_ex_rd),
      .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
      .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_lu_stalls(p_lu), .perf_mem_wait(p_mw), .perf_flushes(p_fl)
`endif
   );

   hazard_ctrl_unit #(.MEM_TIMEOUT(4)) u_dut_t4 (
      .clk(clk), .rst(rst),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
      .id_ex_MemRead(id_ex_MemRead), .id_ex_rd(id_ex_rd),
      .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
      .id_ex_flush(id_ex_flush4), .ex_mem_write(ex_mem_write4),
      .mem_wb_bubble(mem_wb_bubble4), .mem_err(mem_err4)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_lu_stalls(p_lu4), .perf_mem_wait(p_mw4), .perf_flushes(p_fl4)
`endif
   );

   assign ctl  = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble};
   assign ctl4 = {pc_write4, if_id_write4, if_id_flush4, id_ex_flush4, ex_mem_write4, mem_wb_bubble4};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
      if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0; id_ex_MemRead = 1'b0;
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      // Reset: forced control values, registered state cleared.
      tick();
      check("reset_ctl", 32'(ctl), 32'(C_RESET));
      check("reset_mem_err", 32'(mem_err), 32'd0);
      rst = 1'b0; #1;
      check("idle_run", 32'(ctl), 32'(C_RUN));

      // Load-use on rs1: exactly one stall, bubble clears MemRead.
      id_ex_MemRead = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1; #1;
      check("lu_rs1_stall", 32'(ctl), 32'(C_STALL));
      tick();
      id_ex_MemRead = 1'b0; #1;
      check("lu_after_bubble", 32'(ctl), 32'(C_RUN));

      // No hazard when the producer writes x0 or rs1 is not really read.
      id_ex_MemRead = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; #1;
      check("lu_rd_x0", 32'(ctl), 32'(C_RUN));
      id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b0; #1;
      check("lu_rs1_unused", 32'(ctl), 32'(C_RUN));

      // rs2 path: used -> stall, unused -> no stall.
      if_id_rs1 = 5'd7; if_id_uses_rs1 = 1'b1; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b1; #1;
      check("lu_rs2_stall", 32'(ctl), 32'(C_STALL));
      if_id_uses_rs2 = 1'b0; #1;
      check("lu_rs2_unused", 32'(ctl), 32'(C_RUN));

      // Branch outranks load-use.
      if_id_rs1 = 5'd5; ex_branch_taken = 1'b1; #1;
      check("branch_over_lu", 32'(ctl), 32'(C_BRANCH));

      // Memory wait of 3 cycles with a branch in EX: freeze x3, flush on 4th.
      tick();
      idle_inputs();
      ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0; #1;
      check("freeze_c1", 32'(ctl), 32'(C_FREEZE));
      tick();
      check("freeze_c2", 32'(ctl), 32'(C_FREEZE));
      tick();
      check("freeze_c3", 32'(ctl), 32'(C_FREEZE));
      tick();
      dmem_ready = 1'b1; #1;
      check("release_branch", 32'(ctl), 32'(C_BRANCH));
      tick();
      idle_inputs(); #1;
      check("after_wait_run", 32'(ctl), 32'(C_RUN));
      check("short_wait_err", 32'(mem_err), 32'd0);
      check("short_wait_err_t4", 32'(mem_err4), 32'd0);

      // Ready together with a new request: no freeze, stays in RUN.
      dmem_req = 1'b1; dmem_ready = 1'b1; #1;
      check("req_ready_same", 32'(ctl), 32'(C_RUN));
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0; #1;
      check("still_run", 32'(ctl), 32'(C_RUN));

      // Timeout: ready low 6 cycles; t4 instance errs after 4th MEM_WAIT cycle.
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         check($sformatf("tmo_freeze_c%0d", c), 32'(ctl4), 32'(C_FREEZE));
         check($sformatf("tmo_err_t4_c%0d", c), 32'(mem_err4), (c == 6) ? 32'd1 : 32'd0);
         tick();
      end
      check("tmo_err_default", 32'(mem_err), 32'd0);
      check("tmo_keeps_waiting", 32'(ctl4), 32'(C_FREEZE));
      dmem_ready = 1'b1; #1;
      check("tmo_release", 32'(ctl4), 32'(C_RUN));
      tick();
      idle_inputs(); #1;
      check("tmo_err_sticky", 32'(mem_err4), 32'd1);

      // Reset while in MEM_WAIT: back to RUN, error cleared.
      dmem_req = 1'b1; dmem_ready = 1'b0;
      tick();
      rst = 1'b1; #1;
      check("rst_in_wait_ctl", 32'(ctl4), 32'(C_RESET));
      tick();
      rst = 1'b0; idle_inputs(); #1;
      check("rst_back_to_run", 32'(ctl4), 32'(C_RUN));
      check("rst_clears_err", 32'(mem_err4), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
      // Two load-use stalls, three frozen cycles, one flush.
      id_ex_MemRead = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3; if_id_uses_rs1 = 1'b1;
      tick();
      idle_inputs();
      tick();
      id_ex_MemRead = 1'b1; id_ex_rd = 5'd3; if_id_rs2 = 5'd3; if_id_uses_rs2 = 1'b1;
      tick();
      idle_inputs(); dmem_req = 1'b1;
      tick();
      tick();
      tick();
      dmem_ready = 1'b1;
      tick();
      idle_inputs(); ex_branch_taken = 1'b1;
      tick();
      idle_inputs(); #1;
      check("perf_lu_stalls", p_lu, 32'd2);
      check("perf_mem_wait", p_mw, 32'd3);
      check("perf_flushes", p_fl, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
